// File: rtl/fp_pkg.sv
// Shared single-precision definitions for the fp datapath blocks (fpadd, fpmult, converters).
package fp_pkg;
    localparam int          FP_EXP_W  = 8;
    localparam int          FP_FRAC_W = 23;
    localparam int          FP_BIAS   = 127;
    localparam logic [31:0] FP_QNAN   = 32'h7fc00000;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {
        UNPACK, ALIGN, ADD, NORM, PACK, FIN
    } fpadd_state_t;

    function automatic logic fp_is_nan(input fp32_t v);
        return (v.exp == '1) && (v.frac != '0);
    endfunction
endpackage

// File: rtl/fp_lzc.sv
// Combinational 28-bit leading-zero counter; an all-zero input reports 28.
module fp_lzc (
    input  logic [27:0] din,
    output logic [4:0]  cnt
);
    always_comb begin
        cnt = 5'd28;
        // Scanning upward lets the highest set bit win.
        for (int i = 0; i < 28; i++)
            if (din[i]) cnt = 5'(27 - i);
    end
endmodule

// File: rtl/fpadd.sv
// Multi-cycle binary32 adder, fixed 5-cycle latency, start-by-reset / done handshake.
// Define FPADD_ROUND_EN for round-to-nearest-even; otherwise results truncate toward zero.
import fp_pkg::*;

module fpadd (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done
);
`ifdef FPADD_ROUND_EN
    localparam logic RND_EN = 1'b1;
`else
    localparam logic RND_EN = 1'b0;
`endif

    fpadd_state_t       state;
    fp32_t              a, b;
    logic               sgn, sub, spec, zro;
    logic [31:0]        spec_val;
    logic [7:0]         ea, eb;
    logic [23:0]        ma, mb;
    logic [26:0]        ma27, mb27, mn;
    logic [27:0]        sum;
    logic signed [9:0]  ex;

    assign a = dataa;
    assign b = datab;

    // UNPACK: flush denormals, classify specials, order operands by magnitude
    logic        a_zero, b_zero, a_inf, b_inf, swap, spec_c;
    logic [30:0] a_mag, b_mag, big_mag, sml_mag;
    logic [31:0] spec_val_c;
    always_comb begin
        a_zero  = (a.exp == '0);
        b_zero  = (b.exp == '0);
        a_inf   = (a.exp == '1) && (a.frac == '0);
        b_inf   = (b.exp == '1) && (b.frac == '0);
        a_mag   = a_zero ? '0 : {a.exp, a.frac};
        b_mag   = b_zero ? '0 : {b.exp, b.frac};
        swap    = b_mag > a_mag;
        big_mag = swap ? b_mag : a_mag;
        sml_mag = swap ? a_mag : b_mag;
        spec_c     = 1'b1;
        spec_val_c = '0;
        if (fp_is_nan(a) || fp_is_nan(b) || (a_inf && b_inf && (a.sign != b.sign)))
            spec_val_c = FP_QNAN;
        else if (a_inf)
            spec_val_c = dataa;
        else if (b_inf)
            spec_val_c = datab;
        else if (!(a_zero && b_zero))
            spec_c = 1'b0;
    end

    // ALIGN: single barrel shift of B with everything shifted out folded into sticky
    logic [7:0]  diff;
    logic [26:0] mb_ext, lost, mb_al;
    always_comb begin
        diff   = ea - eb;
        mb_ext = {mb, 3'b000};
        lost   = '0;
        if (diff >= 8'd27) begin
            mb_al = {26'd0, |mb_ext};
        end else begin
            lost  = mb_ext & ~(27'h7ffffff << diff[4:0]);
            mb_al = (mb_ext >> diff[4:0]) | {26'd0, |lost};
        end
    end

    // NORM: leading 1 lands on bit 26 of mn
    logic [4:0]        lz;
    logic [26:0]       mn_c;
    logic signed [9:0] ex_n;
    fp_lzc u_lzc (.din(sum), .cnt(lz));
    always_comb begin
        if (sum[27]) begin
            mn_c = {sum[27:2], |sum[1:0]};
            ex_n = ex + 10'sd1;
        end else begin
            mn_c = sum[26:0] << (lz - 5'd1);
            ex_n = ex + 10'sd1 - $signed({5'd0, lz});
        end
    end

    // PACK: round on G/R/S, renormalise a rounding carry, then range-check
    logic [23:0]       mant;
    logic [24:0]       mr;
    logic              rnd;
    logic signed [9:0] pe;
    logic [22:0]       fr;
    logic [31:0]       res_c;
    always_comb begin
        mant = mn[26:3];
        rnd  = RND_EN & mn[2] & (mn[1] | mn[0] | mant[0]);
        mr   = {1'b0, mant} + {24'd0, rnd};
        pe   = mr[24] ? ex + 10'sd1 : ex;
        fr   = mr[24] ? mr[23:1] : mr[22:0];
        if (spec)
            res_c = spec_val;
        else if (zro)
            res_c = '0;
        else if (pe >= 10'sd255)
            res_c = {sgn, 8'hff, 23'd0};
        else if (pe <= 10'sd0)
            res_c = '0;
        else
            res_c = {sgn, pe[7:0], fr};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= UNPACK;
            done   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                UNPACK: begin
                    sgn      <= swap ? b.sign : a.sign;
                    sub      <= a.sign ^ b.sign;
                    ea       <= big_mag[30:23];
                    eb       <= sml_mag[30:23];
                    ma       <= (big_mag[30:23] == '0) ? '0 : {1'b1, big_mag[22:0]};
                    mb       <= (sml_mag[30:23] == '0) ? '0 : {1'b1, sml_mag[22:0]};
                    spec     <= spec_c;
                    spec_val <= spec_val_c;
                    state    <= ALIGN;
                end
                ALIGN: begin
                    ma27  <= {ma, 3'b000};
                    mb27  <= mb_al;
                    ex    <= {2'b00, ea};
                    state <= ADD;
                end
                ADD: begin
                    sum   <= sub ? {1'b0, ma27} - {1'b0, mb27} : {1'b0, ma27} + {1'b0, mb27};
                    state <= NORM;
                end
                NORM: begin
                    mn    <= mn_c;
                    ex    <= ex_n;
                    zro   <= (sum == '0);
                    state <= PACK;
                end
                PACK: begin
                    result <= res_c;
                    done   <= 1'b1;
                    state  <= FIN;
                end
                default: state <= FIN;
            endcase
        end
    end
endmodule

// File: tb/tb_fpadd.sv
// Scoreboard bench for fpadd: directed cases plus random operands checked against an exact-sum model.
module tb_fpadd;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] dataa = '0, datab = '0;
    logic [31:0] result;
    logic        done;

    fpadd dut (.clk(clk), .reset(reset), .dataa(dataa), .datab(datab), .result(result), .done(done));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef FPADD_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    int          n_vec = 0, n_err = 0;
    logic [31:0] q_exp[$], q_a[$], q_b[$];
    int          q_cyc[$];
    logic        mon_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", name, act, req);
        end
    endtask

    // Exact sum in a wide fixed-point integer (LSB = 2^-149), then round/flush per the format rules.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [279:0] va, vb, mag, rem, half;
        logic         s;
        logic [24:0]  m;
        int           ea, eb, p, e;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7fc00000;
        if (ea == 255 && eb == 255) return (a[31] == b[31]) ? a : 32'h7fc00000;
        if (ea == 255) return a;
        if (eb == 255) return b;
        va = (ea == 0) ? '0 : (280'({1'b1, a[22:0]}) << (ea - 1));
        vb = (eb == 0) ? '0 : (280'({1'b1, b[22:0]}) << (eb - 1));
        if (a[31] == b[31]) begin mag = va + vb; s = a[31]; end
        else if (va >= vb)  begin mag = va - vb; s = a[31]; end
        else                begin mag = vb - va; s = b[31]; end
        p = -1;
        for (int i = 0; i < 280; i++) if (mag[i]) p = i;
        if (p < 23) return 32'h0;
        m = 25'(mag >> (p - 23));
        e = p - 22;
        if (p >= 24 && RND) begin
            rem  = mag & ((280'd1 << (p - 23)) - 280'd1);
            half = 280'd1 << (p - 24);
            if (rem > half || (rem == half && m[0])) m = m + 25'd1;
        end
        if (m[24]) begin m = m >> 1; e = e + 1; end
        if (e >= 255) return {s, 8'hff, 23'd0};
        if (e <= 0) return 32'h0;
        return {s, 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp(input int e);
        logic [31:0] v;
        int          k;
        k        = int'($urandom_range(0, 24));
        v[31]    = 1'($urandom);
        v[22:0]  = 23'($urandom);
        v[30:23] = 8'(e);
        if (k == 0) v[30:0] = '0;
        else if (k == 1) begin v[30:23] = 8'hff; v[22:0] = '0; end
        else if (k == 2) begin v[30:23] = 8'hff; v[22] = 1'b1; end
        else if (k == 3) v[30:23] = 8'h00;
        else if (k == 4) v[12:0] = '0;
        return v;
    endfunction

    // Monitor: every rising done pops one expectation and checks value and latency.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1 && mon_prev !== 1'b1) begin
                if (q_exp.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL spurious_done: got result %08h want no completion", result);
                end else begin
                    logic [31:0] e, oa, ob;
                    int          c;
                    e = q_exp.pop_front(); oa = q_a.pop_front(); ob = q_b.pop_front(); c = q_cyc.pop_front();
                    if (result !== e)
                        $display("  operands %08h + %08h", oa, ob);
                    chk("result", result, e);
                    chk("latency", 32'(cyc - c), 32'd5);
                end
            end
            mon_prev = done;
        end
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dataa = a; datab = b; reset = 1'b1;
        @(negedge clk);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        reset = 1'b0;
    endtask

    task automatic expect_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        q_exp.push_back(e); q_a.push_back(a); q_b.push_back(b); q_cyc.push_back(cyc);
    endtask

    task automatic drain();
        int k = 0;
        while (q_exp.size() != 0 && k < 20) begin @(negedge clk); k++; end
        if (q_exp.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: got done=%0b want done=1 within 20 cycles", done);
            q_exp.delete(); q_a.delete(); q_b.delete(); q_cyc.delete();
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        start_op(a, b);
        expect_op(a, b, e);
        drain();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        run_op(32'h40000000, 32'h40400000, 32'h40a00000);
        run_op(32'hbfa00000, 32'h3fc00000, 32'h3e800000);
        run_op(32'hc0400000, 32'hc0300000, 32'hc0b80000);
        run_op(32'h00000000, 32'h40000000, 32'h40000000);
        run_op(32'h3f800000, 32'hbf800000, 32'h00000000);
        run_op(32'h7f800000, 32'hff800000, 32'h7fc00000);
        run_op(32'h7f7fffff, 32'h7f7fffff, 32'h7f800000);
        run_op(32'h3f800000, 32'h33c00000, RND ? 32'h3f800001 : 32'h3f800000);
        run_op(32'h3f800000, 32'h33800000, 32'h3f800000);
        run_op(32'h4b800000, 32'h3f800000, 32'h4b800000);

        // Operands change after done: output must hold.
        run_op(32'h40000000, 32'h40400000, 32'h40a00000);
        dataa = 32'h3f800000; datab = 32'hc2c80000;
        repeat (4) @(negedge clk);
        chk("hold_result", result, 32'h40a00000);
        chk("hold_done", {31'd0, done}, 32'd1);

        // Reset mid-operation: the aborted add must never complete.
        start_op(32'h40000000, 32'h40400000);
        repeat (2) @(negedge clk);
        reset = 1'b1; dataa = 32'h3f800000; datab = 32'h3f800000;
        @(negedge clk);
        chk("midreset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        expect_op(32'h3f800000, 32'h3f800000, 32'h40000000);
        drain();

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a, b;
            int          e1, e2;
            e1 = int'($urandom_range(1, 254));
            if ($urandom_range(0, 3) == 0) e2 = int'($urandom_range(1, 254));
            else begin
                e2 = e1 + int'($urandom_range(0, 60)) - 30;
                if (e2 < 1) e2 = 1;
                if (e2 > 254) e2 = 254;
            end
            a = rnd_fp(e1);
            b = ($urandom_range(0, 15) == 0) ? (a ^ 32'h80000000) : rnd_fp(e2);
            run_op(a, b, ref_add(a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fpadd.md
# fpadd

Multi-cycle IEEE-754 single-precision adder, the accumulate stage directly downstream of `fpmult` in the voice datapath. It sums an `fpmult` product with a running value or a second product, such as an envelope-scaled oscillator plus a mix bus. It uses the same start-by-reset / `done` handshake as `fpmult`, so the sequencer drives both blocks identically. Latency is fixed and no longer than `fpmult`'s, so a mult→add chain has a predictable schedule.

## Interface
- No parameters; the format is fixed to binary32.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; while high, the block is held and the operation is restarted; deassertion starts an add.
- `dataa`  in  32  operand A, IEEE-754 single; must stay stable from reset deassertion until `done`.
- `datab`  in  32  operand B, same rules as `dataa`.
- `result`  out  32  A+B, valid while `done`=1.
- `done`  out  1  high when `result` is valid; stays high until the next reset.

## Operation
- FSM states: UNPACK → ALIGN → ADD → NORM → PACK → FIN. While `reset`=1, the state is UNPACK.
- UNPACK
  - Split sign, 8-bit exponent and 23-bit fraction.
  - Add the hidden bit, giving a 24-bit mantissa. Exponent 0 (zero or denormal) flushes the operand to zero.
  - Swap so the operand with the larger magnitude is A. Compare `{exp, frac}`.
- ALIGN
  - Extend both mantissas to 27 bits by appending guard, round and sticky bits.
  - Right-shift B by `expA - expB` using one barrel shift.
  - Bits shifted out OR into sticky.
  - If the difference is 27 or more, B becomes sticky-only.
- ADD
  - Same signs: 28-bit sum. Different signs: A - B.
  - The result sign is A's sign.
- NORM
  - On carry-out, shift right 1 with sticky OR, and exp += 1.
  - Otherwise, count leading zeros with `fp_lzc` and left-shift by that count, exp -= count.
  - A zero mantissa gives an exact-cancellation result.
- PACK
  - Round, or truncate (see Configuration).
  - If rounding carries out, re-normalise once.
  - Drop the hidden bit and assemble the result.
- FIN
  - `done`=1 and `result` is held.
  - FIN is absorbing until reset.
- Special cases are decided in UNPACK and carried through to PACK as a flag:
  - Either operand NaN, or +inf plus -inf → `0x7fc00000`.
  - One operand inf → that inf.
  - Exact cancellation, or both operands zero → `0x00000000`.
  - Exponent ≥ 255 after normalisation → signed inf (`0x7f800000` / `0xff800000`).
  - Exponent ≤ 0 after normalisation → `0x00000000`. Denormals are flushed.

## Timing
- Reset values: `done`=0, `result`=`32'h0`, state=UNPACK.
- Cycle 0 is the first rising edge with `reset`=0. `done` rises after the 5th edge (edges 0–4 cover UNPACK through PACK).
- Latency is 5 cycles regardless of operands or special case.
- `result` changes only on the edge that raises `done`.
- Reset asserted in any state returns the block to UNPACK on the next edge. `done` and `result` clear on that same edge, and the partial computation is discarded.
- A 1-cycle reset pulse is sufficient.
- Operand changes after `done` have no effect until the next reset.

## Configuration
- `FPADD_ROUND_EN` defined: round to nearest, ties to even, using the guard, round and sticky bits.
- `FPADD_ROUND_EN` undefined: truncate toward zero. G/R/S are computed but ignored. Latency is unchanged.

## Structure
- Shared package `fp_pkg`:
  - `FP_EXP_W`=8, `FP_FRAC_W`=23, `FP_BIAS`=127.
  - `FP_QNAN`=`32'h7fc00000`.
  - `fp32_t` packed struct {sign, exp, frac}.
  - FSM state enum `fpadd_state_t`.
- Sub-module `fp_lzc`: combinational 28-bit leading-zero counter with a 5-bit count output. It is reused by the planned int-to-float converter.

## Test plan
- Run each case with reset for 1 cycle, then check `done` and `result` at cycle 6.
  - `0x40000000`+`0x40400000` (2+3) → `0x40a00000`.
  - `0xbfa00000`+`0x3fc00000` (-1.25+1.5) → `0x3e800000`, via the left-normalise path.
  - `0xc0400000`+`0xc0300000` (-3+-2.75) → `0xc0b80000`, via the carry-out path.
  - `0x00000000`+`0x40000000` → `0x40000000`.
- Cancellation and specials:
  - `0x3f800000`+`0xbf800000` → `0x00000000`.
  - `0x7f800000`+`0xff800000` → `0x7fc00000`.
  - `0x7f7fffff`+`0x7f7fffff` → `0x7f800000`.
- Rounding: `0x3f800000`+`0x33c00000`.
  - With `FPADD_ROUND_EN` → `0x3f800001`; without → `0x3f800000`.
  - Tie case `0x3f800000`+`0x33800000` → `0x3f800000` in both builds.
- Large exponent gap: `0x4b800000`+`0x3f800000` (2^24+1) → `0x4b800000`, with 1 landing in the guard bit.
- Reset mid-operation:
  - Start 2+3, assert reset at cycle 2 for 1 cycle, then present `0x3f800000`+`0x3f800000`.
  - `done` must stay 0 until 5 cycles after the second release, then `result`=`0x40000000`.
- After `done`, change the operands without reset: `result` and `done` hold.
